refresh_engine: RTL and testbench

REFRESH_ENGINE -- requirements
Module: refresh_engine

---
 rtl/gc_dram_pkg.sv | 16 +
 rtl/retention_timer.sv | 52 +++++
 rtl/refresh_engine.sv | 106 ++++++++++
 tb/tb_refresh_engine.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/gc_dram_pkg.sv
// Shared constants and FSM encoding for the gain-cell DRAM refresh slice.
package gc_dram_pkg;

  localparam int unsigned DefRows      = 128;
  localparam int unsigned DefAw        = 7;
  localparam int unsigned DefDw        = 32;
  localparam int unsigned DefRetention = 3000;

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StCap,
    StWb
  } ref_state_e;

endpackage

// File: rtl/retention_timer.sv
// Free-running retention counter; decides when a refresh sweep may start and
// flags a sweep that failed to finish inside the retention window.
module retention_timer
  import gc_dram_pkg::*;
#(
  parameter int unsigned RETENTION = DefRetention
) (
  input  logic clk,
  input  logic rst,
  input  logic sweep_done_i,
  output logic sweep_start_o,
  output logic overrun_o
);

  localparam int unsigned CntW = (RETENTION > 1) ? $clog2(RETENTION) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(RETENTION - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pend_q, pend_d;
  logic            overrun_q, overrun_d;
  logic            wrap;

  always_comb begin
    wrap          = (cnt_q == CntMax);
    // A late sweep still gets its start pulse as soon as the scoreboard catches up.
    sweep_start_o = sweep_done_i && (wrap || pend_q);
    cnt_d         = (wrap || sweep_start_o) ? '0 : cnt_q + CntW'(1);
    pend_d        = pend_q;
    overrun_d     = overrun_q;
    if (sweep_start_o) begin
      pend_d = 1'b0;
    end else if (wrap) begin
      pend_d    = 1'b1;
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      overrun_q <= overrun_d;
    end
  end

  assign overrun_o = overrun_q;

endmodule

// File: rtl/refresh_engine.sv
// Row refresh engine: reads a scoreboard-selected row and writes it straight back,
// yielding the array to the user port whenever it claims it.
module refresh_engine
  import gc_dram_pkg::*;
#(
  parameter int unsigned ROWS      = DefRows,
  parameter int unsigned AW        = DefAw,
  parameter int unsigned DW        = DefDw,
  parameter int unsigned RETENTION = DefRetention
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sweep_done,
  input  logic [AW-1:0] addr_ref,
  input  logic          indicator_ref,
  input  logic          user_active,
  input  logic [DW-1:0] mem_rdata,
  output logic          sweep_start,
  output logic [AW-1:0] mem_addr,
  output logic          mem_re,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  output logic          ref_busy,
  output logic [AW:0]   rows_done,
  output logic          overrun
);

  ref_state_e    state_q, state_d;
  logic [AW-1:0] row_q, row_d;
  logic [DW-1:0] data_q, data_d;
  logic [AW:0]   rows_q, rows_d;

  retention_timer #(
    .RETENTION(RETENTION)
  ) u_retention_timer (
    .clk          (clk),
    .rst          (rst),
    .sweep_done_i (sweep_done),
    .sweep_start_o(sweep_start),
    .overrun_o    (overrun)
  );

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    data_d    = data_q;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      StIdle: begin
        if (!sweep_done && !indicator_ref && !user_active) begin
          state_d = StRd;
          row_d   = addr_ref;
        end
      end
      StRd: begin
        mem_addr = row_q;
        if (!user_active) begin
          mem_re  = 1'b1;
          state_d = StCap;
        end
      end
      // Read data is valid exactly one cycle after the strobe, so capture never stalls.
      StCap: begin
        data_d  = mem_rdata;
        state_d = StWb;
      end
      StWb: begin
        mem_addr  = row_q;
        mem_wdata = data_q;
        if (!user_active) begin
          mem_we  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    rows_d = rows_q;
    if (sweep_start) begin
      rows_d = '0;
    end else if (mem_we && (rows_q < (AW + 1)'(ROWS))) begin
      rows_d = rows_q + (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      row_q   <= '0;
      data_q  <= '0;
      rows_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      data_q  <= data_d;
      rows_q  <= rows_d;
    end
  end

  assign ref_busy  = (state_q != StIdle);
  assign rows_done = rows_q;

endmodule

// File: tb/tb_refresh_engine.sv
// Bench for refresh_engine: a cycle-level behavioural model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_refresh_engine;

  localparam int Ret  = 3000;
  localparam int Rows = 128;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sweep_done = 1'b1;
  logic [6:0]  addr_ref = '0;
  logic        indicator_ref = 1'b1;
  logic        user_active = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        sweep_start;
  logic [6:0]  mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        ref_busy;
  logic [7:0]  rows_done;
  logic        overrun;

  refresh_engine dut (
    .clk          (clk),
    .rst          (rst),
    .sweep_done   (sweep_done),
    .addr_ref     (addr_ref),
    .indicator_ref(indicator_ref),
    .user_active  (user_active),
    .mem_rdata    (mem_rdata),
    .sweep_start  (sweep_start),
    .mem_addr     (mem_addr),
    .mem_re       (mem_re),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .ref_busy     (ref_busy),
    .rows_done    (rows_done),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int n_re = 0;
  int n_we = 0;
  int ss_log[$];
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model. Row progress: 0 none, 1 reading, 2 capturing, 3 writing back.
  int          m_cnt = 0;
  bit          m_pend = 1'b0;
  bit          m_ovr = 1'b0;
  int          m_rows = 0;
  int          m_stage = 0;
  int          m_row = 0;
  logic [31:0] m_data = '0;
  bit          m_ss;
  bit          m_we;

  function bit exp_ss();
    return sweep_done && ((m_cnt == Ret - 1) || m_pend);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0; m_pend = 0; m_ovr = 0; m_rows = 0; m_stage = 0; m_row = 0; m_data = '0;
    end else begin
      m_ss = exp_ss();
      m_we = (m_stage == 3) && !user_active;
      if (m_ss) begin
        m_cnt = 0; m_pend = 0;
      end else if (m_cnt == Ret - 1) begin
        m_cnt = 0; m_pend = 1; m_ovr = 1;
      end else begin
        m_cnt++;
      end
      if (m_ss) m_rows = 0;
      else if (m_we && m_rows < Rows) m_rows++;
      case (m_stage)
        0: if (!sweep_done && !indicator_ref && !user_active) begin
             m_stage = 1; m_row = int'(addr_ref);
           end
        1: if (!user_active) m_stage = 2;
        2: begin m_data = mem_rdata; m_stage = 3; end
        3: if (!user_active) m_stage = 0;
        default: m_stage = 0;
      endcase
    end
  end

  always @(posedge clk) if (!rst) cyc++;

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_sweep_start", 32'(sweep_start), 32'(exp_ss()));
      check("cmp_mem_re", 32'(mem_re), 32'(m_stage == 1 && !user_active));
      check("cmp_mem_we", 32'(mem_we), 32'(m_stage == 3 && !user_active));
      check("cmp_mem_addr", 32'(mem_addr), (m_stage == 1 || m_stage == 3) ? 32'(m_row) : 32'd0);
      check("cmp_mem_wdata", mem_wdata, (m_stage == 3) ? m_data : 32'd0);
      check("cmp_ref_busy", 32'(ref_busy), 32'(m_stage != 0));
      check("cmp_rows_done", 32'(rows_done), 32'(m_rows));
      check("cmp_overrun", 32'(overrun), 32'(m_ovr));
      if (!rst && sweep_start) ss_log.push_back(cyc);
      n_re += int'(mem_re);
      n_we += int'(mem_we);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int base_re;
  int base_we;

  initial begin
    // Reset state
    step(2);
    chk_en = 1'b1;
    check("rst_sweep_start", 32'(sweep_start), 32'd0);
    check("rst_rows_done", 32'(rows_done), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    rst = 1'b0;
    cyc = 0;

    // Sweep start cadence with the scoreboard always done
    while (cyc < 6100) step(1);
    check("ss_count", 32'(ss_log.size()), 32'd2);
    if (ss_log.size() >= 2) begin
      check("ss_first_cycle", 32'(ss_log[0]), 32'd2999);
      check("ss_second_cycle", 32'(ss_log[1]), 32'd5999);
    end

    // Single row refresh of row 5
    sweep_done = 1'b0; indicator_ref = 1'b0; addr_ref = 7'd5; mem_rdata = 32'hA5A5_0001;
    #1;
    check("row5_idle_busy", 32'(ref_busy), 32'd0);
    step(1);
    check("row5_re", 32'(mem_re), 32'd1);
    check("row5_re_addr", 32'(mem_addr), 32'd5);
    indicator_ref = 1'b1; addr_ref = 7'd7;
    step(1);
    check("row5_cap_busy", 32'(ref_busy), 32'd1);
    check("row5_cap_no_we", 32'(mem_we), 32'd0);
    step(1);
    check("row5_we", 32'(mem_we), 32'd1);
    check("row5_we_addr", 32'(mem_addr), 32'd5);
    check("row5_wdata", mem_wdata, 32'hA5A5_0001);
    step(1);
    check("row5_rows_done", 32'(rows_done), 32'd1);
    check("row5_back_idle", 32'(ref_busy), 32'd0);

    // Row already refreshed: nothing happens
    addr_ref = 7'd9;
    base_re = n_re; base_we = n_we;
    step(10);
    check("row9_no_re", 32'(n_re - base_re), 32'd0);
    check("row9_no_we", 32'(n_we - base_we), 32'd0);
    check("row9_rows_done", 32'(rows_done), 32'd1);

    // User port holds the array for 4 cycles during write-back
    addr_ref = 7'd12; indicator_ref = 1'b0; mem_rdata = 32'h1234_5678;
    step(1);
    indicator_ref = 1'b1;
    step(2);
    mem_rdata = 32'hDEAD_BEEF;
    user_active = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("stall_no_we", 32'(mem_we), 32'd0);
      check("stall_addr", 32'(mem_addr), 32'd12);
      check("stall_busy", 32'(ref_busy), 32'd1);
      step(1);
    end
    user_active = 1'b0;
    #1;
    check("stall_we", 32'(mem_we), 32'd1);
    check("stall_we_addr", 32'(mem_addr), 32'd12);
    check("stall_wdata", mem_wdata, 32'h1234_5678);
    step(1);
    check("stall_rows_done", 32'(rows_done), 32'd2);

    // Scoreboard misses the retention deadline
    while (cyc < 9005) step(1);
    check("ovr_set", 32'(overrun), 32'd1);
    check("ovr_no_ss", 32'(ss_log.size()), 32'd2);
    sweep_done = 1'b1;
    #1;
    check("ovr_late_ss", 32'(sweep_start), 32'd1);
    check("ovr_sticky", 32'(overrun), 32'd1);
    step(1);
    check("ovr_ss_one_cycle", 32'(sweep_start), 32'd0);
    check("ovr_still_set", 32'(overrun), 32'd1);
    check("ovr_rows_cleared", 32'(rows_done), 32'd0);

    // Reset lands while the row is in capture
    sweep_done = 1'b0; indicator_ref = 1'b0; addr_ref = 7'd3; mem_rdata = 32'h0BAD_F00D;
    step(1);
    indicator_ref = 1'b1;
    step(1);
    check("rstcap_busy", 32'(ref_busy), 32'd1);
    base_we = n_we;
    rst = 1'b1;
    step(1);
    check("rstcap_idle", 32'(ref_busy), 32'd0);
    check("rstcap_we", 32'(mem_we), 32'd0);
    check("rstcap_re", 32'(mem_re), 32'd0);
    check("rstcap_addr", 32'(mem_addr), 32'd0);
    check("rstcap_wdata", mem_wdata, 32'd0);
    check("rstcap_rows", 32'(rows_done), 32'd0);
    check("rstcap_overrun", 32'(overrun), 32'd0);
    check("rstcap_ss", 32'(sweep_start), 32'd0);
    rst = 1'b0;
    cyc = 0;
    step(5);
    check("rstcap_no_wb", 32'(n_we - base_we), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
